// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: FSM states, Q3.29 arctangent table, pi constants and gain correction.
package cordic_pkg;

  typedef enum logic [2:0] {IDLE, PRE, ITER, COMP, DONE} state_t;

  localparam logic [31:0] PI_HALF = 32'h3243F6A9;
  localparam logic [31:0] PI      = 32'h6487ED51;
  localparam logic [31:0] KINV    = 32'h4DBA76D4;

  // atan(2^-j) in Q3.29, rounded to nearest
  localparam logic [31:0] ATAN_TAB [32] = '{
    32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
    32'h01FF55BC, 32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB,
    32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
    32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000,
    32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
    32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040,
    32'h00000020, 32'h00000010, 32'h00000008, 32'h00000004,
    32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
  };

endpackage

// File: rtl/cordic_vec_step.sv
// One CORDIC vectoring micro-rotation: rotate towards y=0 and accumulate the angle.
module cordic_vec_step #(
  parameter int W  = 34,
  parameter int JW = 5
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [W-1:0]  z,
  input  logic        [JW-1:0] j,
  input  logic signed [W-1:0]  atan,
  output logic signed [W-1:0]  x_nx,
  output logic signed [W-1:0]  y_nx,
  output logic signed [W-1:0]  z_nx
);

  logic signed [W-1:0] xs, ys;

  always_comb begin
    xs = x >>> j;
    ys = y >>> j;
    if (!y[W-1]) begin
      x_nx = x + ys;
      y_nx = y - xs;
      z_nx = z + atan;
    end else begin
      x_nx = x - ys;
      y_nx = y + xs;
      z_nx = z - atan;
    end
  end

endmodule

// File: rtl/cordic_vector_iter.sv
// Iterative CORDIC vectoring unit: Cartesian (x,y) to gain-compensated magnitude and angle.
module cordic_vector_iter
  import cordic_pkg::*;
#(
  parameter int M = 32,
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [M-1:0] x_in,
  input  logic signed [M-1:0] y_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [M-1:0] mag_out,
  output logic signed [M-1:0] ang_out
);

  localparam int W    = M + 2;
  localparam int PW   = W + 33;
  localparam int JW   = $clog2(M);
  localparam int SH_L = (M > 32) ? M - 32 : 0;
  localparam int SH_R = (M < 32) ? 32 - M : 0;
  localparam logic [JW-1:0] JLAST = JW'(N - 1);
  localparam logic signed [PW-1:0] MAG_MAX = PW'({1'b0, {(M-1){1'b1}}});

  // Rescale a Q3.29 package constant to Q3.(M-3) at the internal width.
  function automatic logic signed [W-1:0] scale29(input logic [31:0] v);
    logic signed [W+31:0] t;
    t = signed'({{W{1'b0}}, v});
    return W'((t <<< SH_L) >>> SH_R);
  endfunction

  function automatic logic signed [M-1:0] sat_mag(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p >>> 31;
    if (s[PW-1])          return '0;
    else if (s > MAG_MAX) return {1'b0, {(M-1){1'b1}}};
    else                  return s[M-1:0];
  endfunction

  state_t              state;
  logic [JW-1:0]       j;
  logic signed [W-1:0] x_p0, y_p0, z_p0;
  logic                zero_p0;
  logic signed [PW-1:0] prod_p1;
  logic                comp_ph;

  logic [4:0]          jidx;
  logic signed [W-1:0] atan_c, x_nx, y_nx, z_nx;
  logic signed [PW-1:0] prod_c;

  assign jidx   = 5'(j);
  assign atan_c = scale29(ATAN_TAB[jidx]);
  assign prod_c = PW'(x_p0) * PW'(signed'({1'b0, KINV}));

  cordic_vec_step #(.W(W), .JW(JW)) u_step (
    .x    (x_p0),
    .y    (y_p0),
    .z    (z_p0),
    .j    (j),
    .atan (atan_c),
    .x_nx (x_nx),
    .y_nx (y_nx),
    .z_nx (z_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      j         <= '0;
      x_p0      <= '0;
      y_p0      <= '0;
      z_p0      <= '0;
      zero_p0   <= 1'b0;
      prod_p1   <= '0;
      comp_ph   <= 1'b0;
      mag_out   <= '0;
      ang_out   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_p0     <= {{2{x_in[M-1]}}, x_in};
            y_p0     <= {{2{y_in[M-1]}}, y_in};
            zero_p0  <= (x_in == '0) && (y_in == '0);
            in_ready <= 1'b0;
            state    <= PRE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        // fold the left half-plane into the right so the iterations converge
        PRE: begin
          if (x_p0[W-1] && !y_p0[W-1]) begin
            x_p0 <= y_p0;
            y_p0 <= -x_p0;
            z_p0 <= scale29(PI_HALF);
          end else if (x_p0[W-1]) begin
            x_p0 <= -y_p0;
            y_p0 <= x_p0;
            z_p0 <= -scale29(PI_HALF);
          end else begin
            z_p0 <= '0;
          end
          j     <= '0;
          state <= ITER;
        end
        ITER: begin
          x_p0 <= x_nx;
          y_p0 <= y_nx;
          z_p0 <= z_nx;
          j    <= j + 1'b1;
          if (j == JLAST) state <= COMP;
        end
        // two-cycle gain compensation: register the product, then saturate
        COMP: begin
          if (!comp_ph) begin
            prod_p1 <= prod_c;
            comp_ph <= 1'b1;
          end else begin
            mag_out   <= sat_mag(prod_p1);
            ang_out   <= zero_p0 ? '0 : z_p0[M-1:0];
            out_valid <= 1'b1;
            comp_ph   <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
